fb_fill_arbiter: RTL and testbench

Rectangle-fill engine that owns the framebuffer write port and shares it between two requesters, such as the board renderer and the cursor/highlight logic. Each requester asks for a solid-colour rectangle fill. The block grants requesters round-robin, clips the rectangle to the 640x480 screen, and sweeps it one pixel per clock. The sweep drives write_pos, data_in and wren on the framebuffer.

---
 rtl/fb_fill_arbiter_if.sv | 28 ++
 rtl/fb_fill_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fb_fill_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_fill_arbiter_if.sv
// rtl/fb_fill_arbiter_if.sv - client request/ack bundle and framebuffer write port of the fill engine
interface fb_fill_arbiter_if #(
  parameter int COLOR_W = 3
);
  logic [1:0]             req;
  logic [19:0]            rect_x;
  logic [17:0]            rect_y;
  logic [19:0]            rect_w;
  logic [17:0]            rect_h;
  logic [2*COLOR_W-1:0]   rect_color;
  logic [1:0]             ack;
  logic [1:0]             done;
  logic                   busy;
  logic                   fb_wren;
  logic [8:0]             fb_line;
  logic [9:0]             fb_pixel;
  logic [COLOR_W-1:0]     fb_data;

  modport slave (
    input  req, rect_x, rect_y, rect_w, rect_h, rect_color,
    output ack, done, busy, fb_wren, fb_line, fb_pixel, fb_data
  );

  modport master (
    output req, rect_x, rect_y, rect_w, rect_h, rect_color,
    input  ack, done, busy, fb_wren, fb_line, fb_pixel, fb_data
  );
endinterface

// File: rtl/fb_fill_arbiter.sv
// rtl/fb_fill_arbiter.sv - two-client round-robin rectangle fill engine driving the framebuffer write port
module fb_fill_arbiter #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COLOR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  fb_fill_arbiter_if.slave fill
);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_e;

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 owner_q, owner_d;
  logic [1:0]           ack_q, ack_d;
  logic [1:0]           done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 wren_q, wren_d;
  logic [8:0]           line_q, line_d;
  logic [9:0]           pixel_q, pixel_d;
  logic [9:0]           x_start_q, x_start_d;
  logic [9:0]           x_end_q, x_end_d;
  logic [8:0]           y_end_q, y_end_d;
  logic [COLOR_W-1:0]   data_q, data_d;

  logic                 grant_valid;
  logic                 winner;
  logic [9:0]           sel_x, sel_w;
  logic [8:0]           sel_y, sel_h;
  logic [COLOR_W-1:0]   sel_color;
  logic                 rect_empty;
  logic [10:0]          room_x, w_eff;
  logic [9:0]           room_y, h_eff;

  // A tie goes to the client that was not granted on the previous tie.
  assign grant_valid = |fill.req;
  assign winner      = (&fill.req) ? ~last_grant_q : fill.req[1];

  assign sel_x     = winner ? fill.rect_x[19:10] : fill.rect_x[9:0];
  assign sel_w     = winner ? fill.rect_w[19:10] : fill.rect_w[9:0];
  assign sel_y     = winner ? fill.rect_y[17:9]  : fill.rect_y[8:0];
  assign sel_h     = winner ? fill.rect_h[17:9]  : fill.rect_h[8:0];
  assign sel_color = winner ? fill.rect_color[2*COLOR_W-1:COLOR_W] : fill.rect_color[COLOR_W-1:0];

  assign rect_empty = ({1'b0, sel_x} >= 11'(H_RES)) || ({1'b0, sel_y} >= 10'(V_RES)) ||
                      (sel_w == 10'd0) || (sel_h == 9'd0);

  // Widened one bit so the remaining-room subtraction never wraps once the rect is known non-empty.
  assign room_x = 11'(H_RES) - {1'b0, sel_x};
  assign room_y = 10'(V_RES) - {1'b0, sel_y};
  assign w_eff  = ({1'b0, sel_w} > room_x) ? room_x : {1'b0, sel_w};
  assign h_eff  = ({1'b0, sel_h} > room_y) ? room_y : {1'b0, sel_h};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    ack_d        = 2'b00;
    done_d       = 2'b00;
    busy_d       = busy_q;
    wren_d       = wren_q;
    line_d       = line_q;
    pixel_d      = pixel_q;
    x_start_d    = x_start_q;
    x_end_d      = x_end_q;
    y_end_d      = y_end_q;
    data_d       = data_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          ack_d[winner] = 1'b1;
          owner_d       = winner;
          data_d        = sel_color;
          if (&fill.req) begin
            last_grant_d = winner;
          end
          if (rect_empty) begin
            state_d = FLUSH;
          end else begin
            state_d   = FILL;
            busy_d    = 1'b1;
            wren_d    = 1'b1;
            line_d    = sel_y;
            pixel_d   = sel_x;
            x_start_d = sel_x;
            x_end_d   = sel_x + w_eff[9:0] - 10'd1;
            y_end_d   = sel_y + h_eff[8:0] - 9'd1;
          end
        end
      end

      FILL: begin
        if (pixel_q == x_end_q) begin
          if (line_q == y_end_q) begin
            wren_d          = 1'b0;
            busy_d          = 1'b0;
            done_d[owner_q] = 1'b1;
            state_d         = IDLE;
          end else begin
            pixel_d = x_start_q;
            line_d  = line_q + 9'd1;
          end
        end else begin
          pixel_d = pixel_q + 10'd1;
        end
      end

      FLUSH: begin
        done_d[owner_q] = 1'b1;
        state_d         = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        wren_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      ack_q        <= 2'b00;
      done_q       <= 2'b00;
      busy_q       <= 1'b0;
      wren_q       <= 1'b0;
      line_q       <= '0;
      pixel_q      <= '0;
      x_start_q    <= '0;
      x_end_q      <= '0;
      y_end_q      <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      wren_q       <= wren_d;
      line_q       <= line_d;
      pixel_q      <= pixel_d;
      x_start_q    <= x_start_d;
      x_end_q      <= x_end_d;
      y_end_q      <= y_end_d;
      data_q       <= data_d;
    end
  end

  assign fill.ack      = ack_q;
  assign fill.done     = done_q;
  assign fill.busy     = busy_q;
  assign fill.fb_wren  = wren_q;
  assign fill.fb_line  = line_q;
  assign fill.fb_pixel = pixel_q;
  assign fill.fb_data  = data_q;

endmodule

// File: tb/tb_fb_fill_arbiter.sv
// tb/tb_fb_fill_arbiter.sv - self-checking bench for the two-client rectangle fill engine
module tb_fb_fill_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fb_fill_arbiter_if #(.COLOR_W(3)) bus ();

  fb_fill_arbiter #(.H_RES(640), .V_RES(480), .COLOR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fill  (bus)
  );

  int   errors = 0;
  int   checks = 0;
  logic model_lg;

  task automatic set_client(input int c, input int x, input int y, input int w, input int h, input int col);
    bus.rect_x[c*10 +: 10]   = 10'(x);
    bus.rect_y[c*9 +: 9]     = 9'(y);
    bus.rect_w[c*10 +: 10]   = 10'(w);
    bus.rect_h[c*9 +: 9]     = 9'(h);
    bus.rect_color[c*3 +: 3] = 3'(col);
  endtask

  task automatic apply_reset;
    rst_n          = 1'b0;
    bus.req        = 2'b00;
    bus.rect_x     = '0;
    bus.rect_y     = '0;
    bus.rect_w     = '0;
    bus.rect_h     = '0;
    bus.rect_color = '0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    model_lg = 1'b1;
    @(negedge clk);
  endtask

  // Issues one uncontended request and checks ack, raster-ordered clipped writes and done timing.
  task automatic do_fill(input int c, input int x, input int y, input int w, input int h,
                         input int col, input bit pre_armed, input string tag);
    int  weff, heff, n, k, cyc, bc;
    bit  empty;
    logic [1:0] one_hot;
    one_hot = 2'b01 << c;
    empty = (x >= 640) || (y >= 480) || (w == 0) || (h == 0);
    weff  = empty ? 0 : ((w < 640 - x) ? w : 640 - x);
    heff  = empty ? 0 : ((h < 480 - y) ? h : 480 - y);
    n     = weff * heff;
    if (!pre_armed) begin
      set_client(c, x, y, w, h, col);
      bus.req[c] = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (bus.ack !== one_hot) begin
      errors++;
      $display("FAIL %s ack: got %b expected %b", tag, bus.ack, one_hot);
    end
    bus.req[c] = 1'b0;
    k = 0; cyc = 0; bc = 0;
    while (bus.done === 2'b00 && cyc < 20000) begin
      if (bus.busy === 1'b1) bc++;
      if (bus.fb_wren === 1'b1) begin
        checks++;
        if (k >= n) begin
          errors++;
          $display("FAIL %s extra_write: got write #%0d expected only %0d", tag, k + 1, n);
        end else if (bus.fb_line !== 9'(y + k / weff) || bus.fb_pixel !== 10'(x + k % weff) ||
                     bus.fb_data !== 3'(col)) begin
          errors++;
          $display("FAIL %s write%0d: got (%0d,%0d,d%0d) expected (%0d,%0d,d%0d)", tag, k,
                   bus.fb_line, bus.fb_pixel, bus.fb_data, y + k / weff, x + k % weff, col);
        end
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bus.done !== one_hot) begin
      errors++;
      $display("FAIL %s done: got %b expected %b", tag, bus.done, one_hot);
    end
    checks++;
    if (k != n || bc != n) begin
      errors++;
      $display("FAIL %s count: got writes=%0d busy=%0d expected %0d", tag, k, bc, n);
    end
    checks++;
    if (cyc != (empty ? 1 : n)) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles ack->done expected %0d", tag, cyc, empty ? 1 : n);
    end
    checks++;
    if (bus.fb_wren !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_quiet: got wren=%b busy=%b expected 0 0", tag, bus.fb_wren, bus.busy);
    end
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    bus.req = 2'b00;
    @(negedge clk);
    checks++;
    if ({bus.ack, bus.done, bus.busy, bus.fb_wren, bus.fb_line, bus.fb_pixel, bus.fb_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b done=%b busy=%b wren=%b line=%0d pix=%0d data=%0d expected all 0",
               bus.ack, bus.done, bus.busy, bus.fb_wren, bus.fb_line, bus.fb_pixel, bus.fb_data);
    end
    apply_reset();
  endtask

  task automatic test_single;
    apply_reset();
    do_fill(0, 10, 20, 3, 2, 5, 1'b0, "single");
  endtask

  task automatic test_round_robin;
    logic exp_w;
    apply_reset();
    set_client(0, 1, 1, 1, 1, 2);
    set_client(1, 2, 2, 1, 1, 3);
    bus.req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      exp_w    = ~model_lg;
      model_lg = exp_w;
      @(negedge clk);
      checks++;
      if (bus.ack !== (2'b01 << exp_w) || bus.fb_wren !== 1'b1 || bus.fb_pixel !== (exp_w ? 10'd2 : 10'd1)) begin
        errors++;
        $display("FAIL rr_grant%0d: got ack=%b wren=%b pix=%0d expected ack=%b wren=1 pix=%0d", g,
                 bus.ack, bus.fb_wren, bus.fb_pixel, 2'b01 << exp_w, exp_w ? 2 : 1);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== (2'b01 << exp_w) || bus.fb_wren !== 1'b0) begin
        errors++;
        $display("FAIL rr_done%0d: got done=%b wren=%b expected done=%b wren=0", g, bus.done,
                 bus.fb_wren, 2'b01 << exp_w);
      end
    end
    bus.req = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.ack !== 2'b00) begin
      errors++;
      $display("FAIL rr_release: got ack=%b expected 00", bus.ack);
    end
  endtask

  task automatic test_clip;
    apply_reset();
    do_fill(0, 638, 479, 5, 4, 6, 1'b0, "clip");
  endtask

  task automatic test_empty;
    apply_reset();
    do_fill(0, 100, 100, 0, 3, 1, 1'b0, "empty_w0");
    do_fill(1, 640, 10, 4, 3, 2, 1'b0, "empty_x640");
    do_fill(0, 10, 480, 4, 3, 3, 1'b0, "empty_y480");
  endtask

  task automatic test_reset_mid_fill;
    int k, cyc;
    apply_reset();
    set_client(1, 100, 50, 4, 4, 6);
    bus.req[1] = 1'b1;
    @(negedge clk);
    bus.req[1] = 1'b0;
    k = 0; cyc = 0;
    while (cyc < 50) begin
      if (bus.fb_wren === 1'b1) k++;
      if (k == 3) break;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (k != 3) begin
      errors++;
      $display("FAIL midrst_reach: got %0d writes expected 3", k);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.fb_wren !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 2'b00) begin
      errors++;
      $display("FAIL midrst_async: got wren=%b busy=%b done=%b expected 0 0 00", bus.fb_wren, bus.busy, bus.done);
    end
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    model_lg = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.done !== 2'b00 || bus.fb_wren !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: got done=%b wren=%b expected 00 0", bus.done, bus.fb_wren);
    end
    do_fill(1, 100, 50, 4, 4, 6, 1'b0, "refill");
  endtask

  task automatic test_back_to_back;
    apply_reset();
    do_fill(1, 5, 5, 2, 1, 1, 1'b0, "b2b_first");
    set_client(1, 300, 200, 3, 1, 4);
    bus.req[1] = 1'b1;
    do_fill(1, 300, 200, 3, 1, 4, 1'b1, "b2b_second");
  endtask

  task automatic test_random;
    int c, x, y, w, h, col;
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      c   = int'($urandom_range(0, 1));
      x   = int'($urandom_range(0, 660));
      y   = int'($urandom_range(0, 490));
      w   = int'($urandom_range(0, 40));
      h   = int'($urandom_range(0, 5));
      col = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) x = 600 + int'($urandom_range(0, 39));
      do_fill(c, x, y, w, h, col, 1'b0, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_clip();
    test_empty();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
